sevenseg_scan_driver: RTL
=========================

SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles per digit slot (legal when > GUARD_CYCLES).
REQ-003 Parameter GUARD_CYCLES, default 2, SHALL set the anode-off cycles at the start of each slot.
REQ-004 clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-005 rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 load_valid, input, 1: new display value offered.
REQ-007 load_ready, output, 1: driver can accept a value.
REQ-008 load_data, input, 4*NUM_DIGITS: one nibble per digit; nibble 0 is the rightmost digit.
REQ-009 blank_lz, input, 1: when high, leading zeros are blanked.
REQ-010 disp_en, input, 1: when low, all anodes are off.
REQ-011 seg_n, output, 7: segments a..g, MSB = a, active-low (0 = lit).
REQ-012 an_n, output, NUM_DIGITS: digit anodes, active-low, one-hot-low when driving.

Function
REQ-013 A load SHALL be accepted only on a cycle with load_valid and load_ready both high.
REQ-014 An accepted value SHALL go to a pending register; load_ready SHALL drop the next cycle and stay low until that value is committed.
REQ-015 Pending data SHALL commit to the active register at the frame boundary: slot counter = REFRESH_DIV-1 and digit index = NUM_DIGITS-1. load_ready SHALL rise the following cycle.
REQ-016 Because load_ready is already low on a boundary cycle, no new load can be accepted then; a load offered then SHALL be taken after load_ready rises.
REQ-017 The slot counter SHALL count 0..REFRESH_DIV-1 and wrap. On the wrap, the digit index SHALL advance, with NUM_DIGITS-1 wrapping to 0.
REQ-018 FSM states: GUARD while slot counter < GUARD_CYCLES, otherwise DRIVE. In GUARD, an_n SHALL be all ones.
REQ-019 In DRIVE with disp_en high, an_n SHALL drive bit [index] low and seg_n SHALL show the active nibble [index].
REQ-020 seg_n and an_n SHALL be registered, lagging the counter and index by exactly one cycle.
REQ-021 Decimal encodings (active-low, a..g) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-022 With blank_lz high, a zero nibble SHALL show seg_n all ones when every more-significant nibble is also zero. Digit 0 SHALL never be blanked.
REQ-023 With disp_en low, an_n SHALL be all ones while scanning and loads continue unaffected.

Reset
REQ-024 While rst_n is low: slot counter 0, index 0, active and pending registers 0, pending flag 0, load_ready 1, an_n all ones, seg_n all ones.
REQ-025 A reset mid-frame SHALL discard any uncommitted pending value.

Configuration
REQ-026 With SEVENSEG_HEX_EN defined, nibbles 10..15 SHALL display A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-027 Without SEVENSEG_HEX_EN, nibbles 10..15 SHALL display blank (all ones).

Structure
REQ-028 Package sevenseg_pkg SHALL hold the 7-bit segment typedef, the SEG_BLANK constant and the digit encoding constants.
REQ-029 Sub-module sevenseg_glyph_lut SHALL do the combinational nibble-to-segment mapping, including the SEVENSEG_HEX_EN choice.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-030 Reset release with no load -> an_n=1111 for 3 cycles; then digit 0 driven with seg_n=0000001.
REQ-031 Load 0x1234 -> load_ready low until the boundary after the frame ends; next frame shows 4,3,2,1 on an_n=1110,1101,1011,0111, each preceded by 2 guard cycles.
REQ-032 blank_lz=1, load 0x0070 -> digits 3 and 2 blank, digit 1 = 0001111, digit 0 = 0000001; load 0x0000 -> only digit 0 lit.
REQ-033 load_valid held high through the boundary cycle with 0x5678 -> 0x5678 accepted only after load_ready rises and shown one frame later; the earlier value is not lost.
REQ-034 Load 0x00AF -> with SEVENSEG_HEX_EN, digits show F=0111000 and A=0001000; without it, those digits are blank.
REQ-035 rst_n pulsed low mid-frame with a pending 0x9999 -> outputs go to reset values asynchronously, and 0x0000 is displayed afterwards.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are ordered a..g with a in the MSB. They are active-low,
// so 0 lights a segment and SEG_BLANK turns every segment off.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;

    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sevenseg_glyph_lut.sv
// Combinational lookup from a nibble to an active-low segment pattern.
// Optional feature macro: SEVENSEG_HEX_EN. When it is defined, nibbles 10..15
// show A b C d E F. When it is not defined, those nibbles are blank.
// Ports:
//   nibble : 4-bit digit value
//   seg    : segment pattern a..g, active-low
module sevenseg_glyph_lut
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
`ifdef SEVENSEG_HEX_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`else
            default: seg = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment display driver.
// Each digit owns a slot of REFRESH_DIV clocks. The anodes are held off for
// the first GUARD_CYCLES clocks of every slot so that the digits do not ghost.
// A newly loaded value waits in a pending register and is committed only at
// the frame boundary, so a frame never shows a mix of old and new digits.
// Optional feature macro: SEVENSEG_HEX_EN (hex glyphs, see sevenseg_glyph_lut).
//
// state  | meaning
// GUARD  | slot counter < GUARD_CYCLES, all anodes off
// DRIVE  | current digit anode on and its glyph shown
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load_valid  : new display value offered
//   load_ready  : driver can accept a value
//   load_data   : one nibble per digit, nibble 0 is the rightmost digit
//   blank_lz    : blank leading zeros
//   disp_en     : when low, all anodes are off
//   seg_n       : segments a..g, active-low
//   an_n        : digit anodes, active-low
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank_lz,
    input  logic                    disp_en,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        slot_cnt, slot_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    frame_end;
    scan_state_t             state_q, state_nxt;
    logic [4*NUM_DIGITS-1:0] active_q, pend_q;
    logic                    pend_flag;
    logic [NUM_DIGITS:0]     zero_from;
    logic [3:0]              nib;
    logic                    lead_zero;
    seg_t                    glyph;
    seg_t                    seg_d;
    logic [NUM_DIGITS-1:0]   an_d;

    assign frame_end = (slot_cnt == CNT_LAST) && (idx == IDX_LAST);

    always_comb begin
        slot_nxt = slot_cnt + CNT_W'(1);
        idx_nxt  = idx;
        if (slot_cnt == CNT_LAST) begin
            slot_nxt = '0;
            idx_nxt  = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= slot_nxt;
            idx      <= idx_nxt;
        end
    end

    // The accept and commit branches are mutually exclusive. load_ready is high
    // only when nothing is pending, and a commit needs a pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= '0;
            pend_q     <= '0;
            pend_flag  <= 1'b0;
            load_ready <= 1'b1;
        end else if (load_valid && load_ready) begin
            pend_q     <= load_data;
            pend_flag  <= 1'b1;
            load_ready <= 1'b0;
        end else if (frame_end && pend_flag) begin
            active_q   <= pend_q;
            pend_flag  <= 1'b0;
            load_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (GUARD_CYCLES > 0) ? ST_GUARD : ST_DRIVE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // The state tracks the slot counter, so it is derived from the counter's
    // next value and stays aligned with slot_cnt.
    always_comb begin
        state_nxt = (slot_nxt < CNT_GUARD) ? ST_GUARD : ST_DRIVE;
    end

    // zero_from[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = (active_q[i*4 +: 4] == 4'h0) && zero_from[i+1];
        end
    end

    always_comb begin
        nib       = '0;
        lead_zero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib       = active_q[i*4 +: 4];
                lead_zero = zero_from[i];
            end
        end
    end

    sevenseg_glyph_lut u_glyph (
        .nibble (nib),
        .seg    (glyph)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (state_q == ST_DRIVE && disp_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            seg_d = (blank_lz && lead_zero && idx != '0) ? SEG_BLANK : glyph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_BLANK;
            an_n  <= '1;
        end else begin
            seg_n <= seg_d;
            an_n  <= an_d;
        end
    end

endmodule
